// File: rtl/ntr_pkg.sv
// Shared definitions for the parallel command receiver.
// FSM encodings and default geometry.
package ntr_pkg;

    localparam int DEF_CMD_BYTES = 8;
    localparam int DEF_BUS_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CAPTURE = 2'd1,
        S_HOLD    = 2'd2,
        S_DRAIN   = 2'd3
    } state_t;

endpackage

// File: rtl/word_shifter.sv
// Command register: words enter at the LSB end and move up.
// The first word shifted in ends up in the MSBs.
module word_shifter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   shift,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH*DEPTH-1:0] q
);

    logic [WIDTH*DEPTH-1:0] q_shifted;

    generate
        if (DEPTH == 1) begin : g_single
            assign q_shifted = din;
        end else begin : g_multi
            assign q_shifted = {q[WIDTH*(DEPTH-1)-1:0], din};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            q <= '0;
        end else if (shift) begin
            q <= q_shifted;
        end
    end

endmodule

// File: rtl/parallel_cmd_rx.sv
// Receives a command as CMD_BYTES words from an asynchronous
// parallel bus (ntr_clk / ntr_cs1 / ntr_data) and holds it until acked.
module parallel_cmd_rx
    import ntr_pkg::*;
#(
    parameter int CMD_BYTES   = DEF_CMD_BYTES,
    parameter int BUS_WIDTH   = DEF_BUS_WIDTH,
    parameter int SAMPLE_RISE = 1,
    parameter int SYNC_STAGES = 2,
    localparam int CW = $clog2(CMD_BYTES + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           ntr_clk,
    input  logic                           ntr_cs1,
    input  logic [BUS_WIDTH-1:0]           ntr_data,
    input  logic                           cmd_ack,
    output logic [CMD_BYTES*BUS_WIDTH-1:0] command,
    output logic                           cmd_valid,
    output logic [CW-1:0]                  word_count,
    output logic                           busy,
    output logic                           short_err,
    output logic                           overrun
);

    localparam logic          CLK_IDLE = (SAMPLE_RISE != 0) ? 1'b0 : 1'b1;
    localparam logic [CW-1:0] LAST     = CW'(CMD_BYTES - 1);

    logic [SYNC_STAGES-1:0]                clk_sync;
    logic [SYNC_STAGES-1:0]                cs_sync;
    logic [SYNC_STAGES-1:0][BUS_WIDTH-1:0] data_sync;
    logic                                  clk_prev;

    // Clock, select and data share one chain depth so they stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= {SYNC_STAGES{CLK_IDLE}};
            cs_sync   <= '1;
            data_sync <= '0;
            clk_prev  <= CLK_IDLE;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ntr_clk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], ntr_cs1};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ntr_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    logic                 clk_now;
    logic                 cs_high;
    logic                 sample;
    logic [BUS_WIDTH-1:0] bus_word;

    assign clk_now  = clk_sync[SYNC_STAGES-1];
    assign cs_high  = cs_sync[SYNC_STAGES-1];
    assign bus_word = data_sync[SYNC_STAGES-1];
    assign sample   = (SAMPLE_RISE != 0) ? (clk_now & ~clk_prev)
                                         : (~clk_now & clk_prev);

    state_t        state, state_n;
    logic [CW-1:0] cnt_n;
    logic          short_n;
    logic          over_n;
    logic          shift;
    logic          clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            word_count <= '0;
            short_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_n;
            word_count <= cnt_n;
            short_err  <= short_n;
            overrun    <= over_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = word_count;
        short_n = short_err;
        over_n  = overrun;
        shift   = 1'b0;
        clear   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!cs_high) begin
                    state_n = S_CAPTURE;
                    cnt_n   = '0;
                    short_n = 1'b0;
                    over_n  = 1'b0;
                    clear   = 1'b1;
                end
            end
            S_CAPTURE: begin
                // A select rise beats a coincident sample edge.
                if (cs_high) begin
                    state_n = S_IDLE;
                    short_n = 1'b1;
                end else if (sample) begin
                    shift = 1'b1;
                    cnt_n = word_count + 1'b1;
                    if (word_count == LAST) begin
                        state_n = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (sample) begin
                    over_n = 1'b1;
                end
                if (cmd_ack) begin
                    state_n = cs_high ? S_IDLE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (sample) begin
                    over_n = 1'b1;
                end
                if (cs_high) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign cmd_valid = (state == S_HOLD);
    assign busy      = (state == S_CAPTURE);

    word_shifter #(
        .WIDTH (BUS_WIDTH),
        .DEPTH (CMD_BYTES)
    ) u_shifter (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .shift (shift),
        .din   (bus_word),
        .q     (command)
    );

endmodule

// File: tb/tb_parallel_cmd_rx.sv
// Self-checking bench for parallel_cmd_rx: default instance plus a
// 4x16 falling-edge instance.
module tb_parallel_cmd_rx;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_ntr_clk, a_cs, a_ack;
    logic [7:0]  a_data;
    logic [63:0] a_command;
    logic        a_valid, a_busy, a_short, a_over;
    logic [3:0]  a_count;

    parallel_cmd_rx u_a (
        .clk        (clk),
        .rst        (rst),
        .ntr_clk    (a_ntr_clk),
        .ntr_cs1    (a_cs),
        .ntr_data   (a_data),
        .cmd_ack    (a_ack),
        .command    (a_command),
        .cmd_valid  (a_valid),
        .word_count (a_count),
        .busy       (a_busy),
        .short_err  (a_short),
        .overrun    (a_over)
    );

    logic        b_ntr_clk, b_cs, b_ack;
    logic [15:0] b_data;
    logic [63:0] b_command;
    logic        b_valid, b_busy, b_short, b_over;
    logic [2:0]  b_count;

    parallel_cmd_rx #(
        .CMD_BYTES   (4),
        .BUS_WIDTH   (16),
        .SAMPLE_RISE (0)
    ) u_b (
        .clk        (clk),
        .rst        (rst),
        .ntr_clk    (b_ntr_clk),
        .ntr_cs1    (b_cs),
        .ntr_data   (b_data),
        .cmd_ack    (b_ack),
        .command    (b_command),
        .cmd_valid  (b_valid),
        .word_count (b_count),
        .busy       (b_busy),
        .short_err  (b_short),
        .overrun    (b_over)
    );

    int pass_cnt = 0;
    int total    = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [63:0] sb[$];
    logic        valid_d = 1'b0;

    always @(negedge clk) begin
        if (a_valid && !valid_d) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_valid", 64'(a_valid), 64'd0);
            end else begin
                check("sb_command", a_command, sb.pop_front());
            end
        end
        valid_d <= a_valid;
    end

    typedef struct {
        int          n;
        logic [79:0] words;
        bit          exp_valid;
        logic [63:0] exp_cmd;
        bit          exp_short;
        bit          exp_over;
        int          exp_cnt;
        bit          ack_late;
    } vec_t;

    vec_t vecs[5];

    task automatic a_word(input logic [7:0] w, input bit timed);
        int lat;
        lat = 0;
        a_data = w;
        repeat (3) @(negedge clk);
        a_ntr_clk = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            if (a_valid && lat == 0) lat = i;
        end
        if (timed) check("valid_latency", 64'(lat), 64'd3);
        a_ntr_clk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        if (v.exp_valid) sb.push_back(v.exp_cmd);
        a_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < v.n; i++) begin
            a_word(v.words[79-8*i -: 8], v.exp_valid && i == 7);
        end
        repeat (2) @(negedge clk);
        check("valid_after_words", 64'(a_valid), 64'(v.exp_valid));
        if (v.exp_valid && !v.ack_late) begin
            a_ack = 1'b1;
            @(negedge clk);
            a_ack = 1'b0;
            @(negedge clk);
            check("valid_drop_on_ack", 64'(a_valid), 64'd0);
        end
        a_cs = 1'b1;
        repeat (5) @(negedge clk);
        check("short_err", 64'(a_short), 64'(v.exp_short));
        check("overrun", 64'(a_over), 64'(v.exp_over));
        check("word_count", 64'(a_count), 64'(v.exp_cnt));
        if (v.ack_late) begin
            check("valid_held_cs_high", 64'(a_valid), 64'd1);
            check("command_held", a_command, v.exp_cmd);
            a_ack = 1'b1;
            @(negedge clk);
            a_ack = 1'b0;
            @(negedge clk);
            check("valid_drop_late_ack", 64'(a_valid), 64'd0);
        end
        check("busy_idle", 64'(a_busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{8, 80'h9F00000000000000_0000, 1'b1,
                    64'h9F00000000000000, 1'b0, 1'b0, 8, 1'b0};
        vecs[1] = '{8, 80'h0102030405060708_0000, 1'b1,
                    64'h0102030405060708, 1'b0, 1'b0, 8, 1'b0};
        vecs[2] = '{5, 80'hA1B2C3D4E5_0000000000, 1'b0,
                    64'h0, 1'b1, 1'b0, 5, 1'b0};
        vecs[3] = '{10, 80'h1122334455667788_99AA, 1'b1,
                    64'h1122334455667788, 1'b0, 1'b1, 8, 1'b1};
        vecs[4] = '{1, 80'h5A000000000000000000, 1'b0,
                    64'h0, 1'b1, 1'b0, 1, 1'b0};

        rst = 1'b1;
        a_ntr_clk = 1'b0; a_cs = 1'b1; a_ack = 1'b0; a_data = '0;
        b_ntr_clk = 1'b1; b_cs = 1'b1; b_ack = 1'b0; b_data = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_command", a_command, 64'd0);
        check("rst_valid", 64'(a_valid), 64'd0);
        check("rst_busy", 64'(a_busy), 64'd0);
        check("rst_count", 64'(a_count), 64'd0);
        check("rst_flags", 64'({a_short, a_over}), 64'd0);
        check("rst_b_state", 64'({b_valid, b_busy, b_count}), 64'd0);

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // Reset mid-transfer, then a clean transfer.
        a_cs = 1'b0;
        repeat (4) @(negedge clk);
        a_word(8'hC1, 1'b0);
        a_word(8'hC2, 1'b0);
        a_word(8'hC3, 1'b0);
        check("pre_rst_busy", 64'(a_busy), 64'd1);
        rst = 1'b1;
        a_cs = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_command", a_command, 64'd0);
        check("midrst_count", 64'(a_count), 64'd0);
        check("midrst_ctrl",
              64'({a_valid, a_busy, a_short, a_over}), 64'd0);
        run_vec(vecs[1]);

        // Eighth sample edge and select rise land in the same cycle.
        a_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 7; i++) a_word(8'(i + 1), 1'b0);
        a_data = 8'h88;
        repeat (3) @(negedge clk);
        a_ntr_clk = 1'b1;
        a_cs = 1'b1;
        repeat (6) @(negedge clk);
        check("same_cycle_short", 64'(a_short), 64'd1);
        check("same_cycle_valid", 64'(a_valid), 64'd0);
        check("same_cycle_count", 64'(a_count), 64'd7);
        a_ntr_clk = 1'b0;
        repeat (4) @(negedge clk);

        // 4 x 16-bit words on falling edges.
        b_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            logic [63:0] bw;
            bw = 64'h123456789ABCDEF0;
            b_data = bw[63-16*i -: 16];
            repeat (3) @(negedge clk);
            b_ntr_clk = 1'b0;
            repeat (4) @(negedge clk);
            b_ntr_clk = 1'b1;
            repeat (4) @(negedge clk);
        end
        check("b_valid", 64'(b_valid), 64'd1);
        check("b_command", b_command, 64'h123456789ABCDEF0);
        check("b_count", 64'(b_count), 64'd4);
        b_ack = 1'b1;
        @(negedge clk);
        b_ack = 1'b0;
        b_cs = 1'b1;
        repeat (4) @(negedge clk);
        check("b_valid_drop", 64'(b_valid), 64'd0);
        check("b_flags", 64'({b_short, b_over}), 64'd0);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/parallel_cmd_rx.md
PARALLEL_CMD_RX -- requirements
Module: parallel_cmd_rx

Interface
REQ-001 Parameter CMD_BYTES, default 8: number of bus words per command; legal range 1..16.
REQ-002 Parameter BUS_WIDTH, default 8: width of one bus word.
REQ-003 Parameter SAMPLE_RISE, default 1: 1 samples on bus-clock rising edge, 0 on falling edge.
REQ-004 Parameter SYNC_STAGES, default 2: synchroniser depth for ntr_clk, ntr_cs1 and ntr_data; legal range 2..4.
REQ-005 clk  in  1  system clock; the single clock, all logic on posedge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ntr_clk  in  1  asynchronous bus clock.
REQ-008 ntr_cs1  in  1  asynchronous chip select, active-low.
REQ-009 ntr_data  in  BUS_WIDTH  asynchronous bus data.
REQ-010 cmd_ack  in  1  consumer acknowledge of a held command.
REQ-011 command  out  CMD_BYTES*BUS_WIDTH  assembled command.
REQ-012 cmd_valid  out  1  command complete and held.
REQ-013 word_count  out  clog2(CMD_BYTES+1)  words captured in the current transfer.
REQ-014 busy  out  1  transfer in progress (CAPTURE state).
REQ-015 short_err  out  1  sticky: cs1 rose before CMD_BYTES words were captured.
REQ-016 overrun  out  1  sticky: sample edge seen after the command was complete.

Function
REQ-017 ntr_clk, ntr_cs1 and ntr_data SHALL each pass through SYNC_STAGES flops, so data stays aligned with the synchronised clock.
REQ-018 A sample event SHALL be one clk cycle in which the synchronised ntr_clk shows the selected edge (previous vs current stage).
REQ-019 The FSM SHALL have four states, IDLE, CAPTURE, HOLD and DRAIN, with the transitions in REQ-020 to REQ-024.
REQ-020 IDLE to CAPTURE when synchronised cs1 is low; word_count SHALL be cleared on entry.
REQ-021 In CAPTURE, each sample event SHALL shift the synchronised data in at the LSB end with the existing contents moving up one word, so the first word ends in the MSBs, and SHALL increment word_count.
REQ-022 CAPTURE to HOLD on the cycle after the sample event that brings word_count to CMD_BYTES; cmd_valid SHALL go high in that same cycle. Latency from that synchronised edge to cmd_valid is 1 clk.
REQ-023 HOLD: command SHALL be frozen and cmd_valid held high; when cmd_ack=1, go to DRAIN and drop cmd_valid the next cycle.
REQ-024 DRAIN: no capture takes place; return to IDLE when synchronised cs1 is high.
REQ-025 A sample event in HOLD or DRAIN SHALL set overrun and SHALL leave command unchanged.
REQ-026 cs1 high in CAPTURE SHALL return to IDLE, set short_err, and not assert cmd_valid; if a sample event and cs1-high occur in the same cycle, the cs1 abort wins.
REQ-027 cs1 high in HOLD SHALL keep cmd_valid and the command until cmd_ack, then go directly to IDLE.
REQ-028 cmd_ack outside HOLD SHALL be ignored.
REQ-029 short_err and overrun SHALL clear only on the IDLE-to-CAPTURE transition or on reset.
REQ-030 With CMD_BYTES=1, a single sample event SHALL complete the command.

Reset
REQ-031 On rst: state=IDLE; command=0; cmd_valid=0; busy=0; word_count=0; short_err=0; overrun=0; all synchroniser flops set to idle levels (clk stage 1 if SAMPLE_RISE=0, else 0; cs1 stages 1; data stages 0).
REQ-032 Reset mid-transfer SHALL discard partial data; after reset release a new transfer starts only on a fresh cs1-low seen in IDLE.

Structure
REQ-033 Shared package ntr_pkg SHALL hold the FSM state encodings and the default CMD_BYTES and BUS_WIDTH values.
REQ-034 One sub-module, word_shifter (parametrised width and depth, with shift-enable and clear), SHALL implement the command register.

Verification
REQ-035 Defaults; cs1 low, 8 rising edges carrying 0x9F,0x00,0x00,0x00,0x00,0x00,0x00,0x00 -> command=0x9F00000000000000, cmd_valid high 1 clk after the 8th synchronised edge; ack -> cmd_valid low.
REQ-036 cs1 rises after 5 words -> short_err=1, cmd_valid never asserts, word_count=5 remains readable until the next transfer.
REQ-037 10 edges before cs1 rises, no ack until the end -> overrun=1, command holds the first 8 words.
REQ-038 CMD_BYTES=4, BUS_WIDTH=16, SAMPLE_RISE=0; words 0x1234,0x5678,0x9ABC,0xDEF0 on falling edges -> command=0x123456789ABCDEF0.
REQ-039 rst asserted after 3 words -> all outputs 0; a following complete transfer captures correctly.
REQ-040 Sample edge and cs1 rise synchronised in the same cycle on the 8th word -> short_err=1, cmd_valid=0.
